// File: rtl/in_fifo_pkg.sv
// Shared widths, word layout and flow-control constants for the in_fifo_chain node relay.
package in_fifo_pkg;

  localparam int unsigned DEF_CHAN_W = 12;
  localparam int unsigned DEF_DATA_W = 128;
  localparam int unsigned XOFF_HYST  = 2;

  function automatic int unsigned word_width(input int unsigned chan_w, input int unsigned data_w);
    return chan_w + 2 + data_w;
  endfunction

  // Word layout as carried between stages: channel in the MSBs, payload in the LSBs.
  typedef struct packed {
    logic [DEF_CHAN_W-1:0] chan;
    logic                  sop;
    logic                  eop;
    logic [DEF_DATA_W-1:0] data;
  } word_t;

endpackage

// File: rtl/chain_stage_fifo.sv
// One relay stage: inferred-RAM FIFO with registered read data and a one-cycle q_valid pulse.
module chain_stage_fifo #(
  parameter int unsigned WIDTH = 142,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wrreq,
  input  logic [WIDTH-1:0]       data,
  input  logic                   rdreq,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic [AW:0]      w_level_d;
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;

  always_ff @(posedge clock) begin
    if (wrreq) r_mem[r_wptr] <= data;
  end

  always_comb begin
    w_level_d = r_level;
    unique case ({wrreq, rdreq})
      2'b10:   w_level_d = r_level + (AW+1)'(1);
      2'b01:   w_level_d = r_level - (AW+1)'(1);
      default: w_level_d = r_level;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else begin
      if (wrreq) r_wptr <= r_wptr + AW'(1);
      if (rdreq) begin
        r_rptr <= r_rptr + AW'(1);
        r_q    <= r_mem[r_rptr];
      end
      r_q_valid <= rdreq;
      r_level   <= w_level_d;
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign level   = r_level;
  assign empty   = (r_level == '0);
  // DEPTH is a power of two, so the level MSB alone marks a full stage.
  assign full    = r_level[AW];

endmodule

// File: rtl/in_fifo_chain.sv
// Relays an Avalon-ST stream through NCOUNT buffered node stages with credit-based forwarding.
// Define IN_FIFO_CHAIN_FRAME_CHK_EN to enable sop/eop framing checks with a sticky frame_err.
module in_fifo_chain
  import in_fifo_pkg::*;
#(
  parameter int unsigned NCOUNT    = 8,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned CHAN_W    = 12,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = 12
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic [DATA_W-1:0]                           st_data,
  input  logic                                        st_sop,
  input  logic                                        st_eop,
  input  logic                                        st_valid,
  input  logic [CHAN_W-1:0]                           st_channel,
  output logic                                        st_ready,
  input  logic [NCOUNT-1:0]                           node_bypass,
  input  logic [NCOUNT-1:0]                           pnode_ready,
  output logic [NCOUNT*word_width(CHAN_W, DATA_W)-1:0] pnode_data,
  output logic [NCOUNT-1:0]                           pnode_valid,
  output logic                                        xoff,
  output logic                                        frame_err
);

  localparam int unsigned W          = word_width(CHAN_W, DATA_W);
  localparam int unsigned LW         = $clog2(DEPTH) + 1;
  localparam logic [LW:0] CREDIT_MAX = (LW+1)'(DEPTH - 1);
  localparam int          XOFF_CLR   = int'(AF_THRESH) - int'(XOFF_HYST);

  logic [NCOUNT-1:0] w_wr;
  logic [NCOUNT-1:0] w_rd;
  logic [NCOUNT-1:0] w_empty;
  logic [NCOUNT-1:0] w_full;
  logic [NCOUNT-1:0] w_out_v;
  logic [W-1:0]      w_wdata [NCOUNT];
  logic [W-1:0]      w_out_q [NCOUNT];
  logic [LW-1:0]     w_level [NCOUNT];
  logic              w_accept;
  logic              w_wr0;
  logic              r_xoff;
  logic              w_xoff_d;

  assign st_ready = !reset && !w_full[0];
  assign w_accept = st_valid && st_ready;

`ifdef IN_FIFO_CHAIN_FRAME_CHK_EN
  logic r_in_pkt;
  logic r_frame_err;
  logic w_bad;

  assign w_bad = st_sop ? r_in_pkt : !r_in_pkt;
  assign w_wr0 = w_accept && !w_bad;

  // A bad beat is consumed from the source but never written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_in_pkt    <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (w_accept) begin
      r_in_pkt <= (st_sop || r_in_pkt) && !st_eop;
      if (w_bad) r_frame_err <= 1'b1;
    end
  end

  assign frame_err = r_frame_err;
`else
  assign w_wr0     = w_accept;
  assign frame_err = 1'b0;
`endif

  for (genvar i = 0; i < NCOUNT; i++) begin : g_stage
    logic w_credit;

    if (i == 0) begin : g_head
      assign w_wr[i]    = w_wr0;
      assign w_wdata[i] = {st_channel, st_sop, st_eop, st_data};
    end else begin : g_link
      assign w_wr[i]    = w_out_v[i-1];
      assign w_wdata[i] = w_out_q[i-1];
    end

    // A word already in out_q counts against the downstream stage's free space.
    if (i < NCOUNT - 1) begin : g_credit
      assign w_credit = !w_full[i+1] &&
                        (({1'b0, w_level[i+1]} + (LW+1)'(w_out_v[i])) <= CREDIT_MAX);
    end else begin : g_tail
      assign w_credit = 1'b1;
    end

    assign w_rd[i] = !w_empty[i] && (pnode_ready[i] || node_bypass[i]) && w_credit;

    chain_stage_fifo #(
      .WIDTH (W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .wrreq   (w_wr[i]),
      .data    (w_wdata[i]),
      .rdreq   (w_rd[i]),
      .q       (w_out_q[i]),
      .q_valid (w_out_v[i]),
      .level   (w_level[i]),
      .empty   (w_empty[i]),
      .full    (w_full[i])
    );

    assign pnode_data[i*W +: W] = w_out_q[i];
    assign pnode_valid[i]       = w_out_v[i] && !node_bypass[i];
  end

  always_comb begin
    w_xoff_d = r_xoff;
    if (int'(w_level[0]) >= int'(AF_THRESH)) begin
      w_xoff_d = 1'b1;
    end else if (int'(w_level[0]) < XOFF_CLR) begin
      w_xoff_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_xoff <= 1'b0;
    else       r_xoff <= w_xoff_d;
  end

  assign xoff = r_xoff;

endmodule

// File: tb/tb_in_fifo_chain.sv
// Scoreboard bench for in_fifo_chain: driver queues expected words per node, a monitor checks them.
module tb_in_fifo_chain;
  import in_fifo_pkg::*;

  localparam int NCOUNT = 4;
  localparam int DEPTH  = 16;
  localparam int W      = $bits(word_t);

  logic                  clock;
  logic                  reset;
  logic [127:0]          st_data;
  logic                  st_sop;
  logic                  st_eop;
  logic                  st_valid;
  logic [11:0]           st_channel;
  logic                  st_ready;
  logic [NCOUNT-1:0]     node_bypass;
  logic [NCOUNT-1:0]     pnode_ready;
  logic [NCOUNT*W-1:0]   pnode_data;
  logic [NCOUNT-1:0]     pnode_valid;
  logic                  xoff;
  logic                  frame_err;

  in_fifo_chain #(
    .NCOUNT    (NCOUNT),
    .DATA_W    (128),
    .CHAN_W    (12),
    .DEPTH     (DEPTH),
    .AF_THRESH (12)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .st_data     (st_data),
    .st_sop      (st_sop),
    .st_eop      (st_eop),
    .st_valid    (st_valid),
    .st_channel  (st_channel),
    .st_ready    (st_ready),
    .node_bypass (node_bypass),
    .pnode_ready (pnode_ready),
    .pnode_data  (pnode_data),
    .pnode_valid (pnode_valid),
    .xoff        (xoff),
    .frame_err   (frame_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;
  int     wr_cnt  = 0;
  int     stalls  = 0;
  longint in_cyc  = 0;
  logic   tb_drop = 1'b0;
  logic   m_xoff  = 1'b0;
  logic   m_ferr  = 1'b0;
  logic   m_in_pkt = 1'b0;
  word_t  exp_q [NCOUNT][$];
  int     n_seen [NCOUNT];
  longint arr_first [NCOUNT];
  longint arr_last [NCOUNT];

  function automatic void check(input string name, input logic [159:0] act,
                                input logic [159:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  function automatic word_t mk(input int unsigned base, input int unsigned n, input logic sop,
                               input logic eop);
    word_t w;
    w.chan = 12'(base + n);
    w.sop  = sop;
    w.eop  = eop;
    w.data = {32'(base), 32'(n), ~32'(n), 32'(base ^ n)};
    return w;
  endfunction

  function automatic logic queues_empty();
    logic e = 1'b1;
    for (int i = 0; i < NCOUNT; i++) if (exp_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // Framing model: a misframed beat is consumed but produces nothing downstream.
  function automatic void accept(input word_t w);
    logic drop = 1'b0;
`ifdef IN_FIFO_CHAIN_FRAME_CHK_EN
    drop = w.sop ? m_in_pkt : !m_in_pkt;
    if (drop) m_ferr = 1'b1;
    m_in_pkt = (w.sop || m_in_pkt) && !w.eop;
`endif
    tb_drop = drop;
    in_cyc  = cyc;
    if (!drop) for (int i = 0; i < NCOUNT; i++) if (!node_bypass[i]) exp_q[i].push_back(w);
  endfunction

  task automatic drive(input word_t w);
    st_channel = w.chan;
    st_sop     = w.sop;
    st_eop     = w.eop;
    st_data    = w.data;
    st_valid   = 1'b1;
  endtask

  task automatic send(input word_t w);
    int waits = 0;
    @(negedge clock);
    drive(w);
    while (!st_ready && waits < 500) begin
      @(negedge clock);
      waits++;
    end
    stalls += waits;
    if (!st_ready) check("send_ready", st_ready, 1);
    else accept(w);
  endtask

  task automatic idle();
    @(negedge clock);
    st_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (!queues_empty() && n < 2000) begin
      @(negedge clock);
      n++;
    end
    repeat (20) @(negedge clock);
    check("drain", queues_empty(), 1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    reset    = 1'b1;
    st_valid = 1'b0;
    #1;
    check("rst_valid", pnode_valid, 0);
    check("rst_xoff", xoff, 0);
    check("rst_ready", st_ready, 0);
    check("rst_ferr", frame_err, 0);
    for (int i = 0; i < NCOUNT; i++) begin
      check($sformatf("rst_data%0d", i), pnode_data[i*W +: W], 0);
      exp_q[i].delete();
    end
    m_in_pkt = 1'b0;
    m_ferr   = 1'b0;
    repeat (2) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("rel_ready", st_ready, 1);
  endtask

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) wr_cnt <= 0;
    else if (st_valid && st_ready && !tb_drop) wr_cnt <= wr_cnt + 1;
  end

  // Monitor: per-node scoreboard plus a reference model of xoff from the stage-0 occupancy.
  always @(negedge clock) begin
    int lvl0;
    word_t e;
    if (reset) begin
      for (int i = 0; i < NCOUNT; i++) n_seen[i] = 0;
      m_xoff = 1'b0;
    end else begin
      for (int i = 0; i < NCOUNT; i++) begin
        if (pnode_valid[i]) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("node%0d_extra", i), pnode_valid[i], 0);
          end else begin
            e = exp_q[i].pop_front();
            check($sformatf("node%0d_word", i), pnode_data[i*W +: W], e);
          end
          if (n_seen[i] == 0) arr_first[i] = cyc;
          arr_last[i] = cyc;
          n_seen[i]++;
        end
      end
      lvl0 = wr_cnt - n_seen[0];
      check("xoff", xoff, m_xoff);
      if (lvl0 >= 12) m_xoff = 1'b1;
      else if (lvl0 < 10) m_xoff = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

  initial begin
    word_t w;
    int    n;
    int    run;
    reset       = 1'b1;
    st_valid    = 1'b0;
    st_sop      = 1'b0;
    st_eop      = 1'b0;
    st_data     = '0;
    st_channel  = '0;
    node_bypass = '0;
    pnode_ready = '1;

    // Single beat: latency 2 cycles per stage.
    do_reset();
    w.chan = 12'd5;
    w.sop  = 1'b1;
    w.eop  = 1'b1;
    w.data = 128'hABCD;
    send(w);
    idle();
    wait_drain();
    for (int i = 0; i < NCOUNT; i++) begin
      check($sformatf("single_cnt%0d", i), n_seen[i], 1);
      check($sformatf("single_lat%0d", i), arr_first[i] - in_cyc, 2 * (i + 1));
    end

    // Streaming: 100 back-to-back beats, one per cycle everywhere.
    do_reset();
    stalls = 0;
    for (int k = 0; k < 100; k++) send(mk(32'h100, k, k == 0, k == 99));
    idle();
    wait_drain();
    check("stream_stalls", stalls, 0);
    for (int i = 0; i < NCOUNT; i++) begin
      check($sformatf("stream_cnt%0d", i), n_seen[i], 100);
      check($sformatf("stream_rate%0d", i), arr_last[i] - arr_first[i], 99);
    end

    // Stalled last node: the chain holds 4*DEPTH words before st_ready falls.
    do_reset();
    pnode_ready = 4'b0111;
    n   = 0;
    run = 0;
    for (int c = 0; c < 400 && run < 8; c++) begin
      @(negedge clock);
      w = mk(32'h200, n, n == 0, 1'b0);
      drive(w);
      if (st_ready) begin
        accept(w);
        n++;
        run = 0;
      end else begin
        run++;
      end
    end
    st_valid = 1'b0;
    check("stall_accepted", n, 4 * DEPTH);
    check("stall_ready", st_ready, 0);
    check("stall_xoff", xoff, 1);
    check("stall_seen0", n_seen[0], 3 * DEPTH);
    check("stall_seen1", n_seen[1], 2 * DEPTH);
    check("stall_seen2", n_seen[2], DEPTH);
    check("stall_seen3", n_seen[3], 0);
    pnode_ready = '1;
    wait_drain();
    check("stall_drain3", n_seen[3], 4 * DEPTH);
    check("stall_xoff_clr", xoff, 0);

    // Bypass: node 1 skipped and not ready, downstream still fed.
    do_reset();
    node_bypass = 4'b0010;
    pnode_ready = 4'b1101;
    for (int k = 0; k < 20; k++) send(mk(32'h300, k, k == 0, k == 19));
    idle();
    wait_drain();
    check("byp_seen1", n_seen[1], 0);
    check("byp_seen2", n_seen[2], 20);
    check("byp_seen3", n_seen[3], 20);
    node_bypass = '0;
    pnode_ready = '1;

    // Framing: sop, data, sop (misframed), eop.
    do_reset();
    send(mk(32'h400, 0, 1'b1, 1'b0));
    send(mk(32'h400, 1, 1'b0, 1'b0));
    send(mk(32'h400, 2, 1'b1, 1'b0));
    send(mk(32'h400, 3, 1'b0, 1'b1));
    idle();
    wait_drain();
`ifdef IN_FIFO_CHAIN_FRAME_CHK_EN
    check("frame_err", frame_err, 1);
    check("frame_cnt", n_seen[3], 3);
`else
    check("frame_err", frame_err, 0);
    check("frame_cnt", n_seen[3], 4);
`endif

    // Reset with 7 words buffered, then a fresh packet with no leftovers.
    do_reset();
    pnode_ready = '0;
    for (int k = 0; k < 7; k++) send(mk(32'h500, k, k == 0, 1'b0));
    idle();
    repeat (3) @(negedge clock);
    do_reset();
    pnode_ready = '1;
    for (int k = 0; k < 3; k++) send(mk(32'h600, k, k == 0, k == 2));
    idle();
    wait_drain();
    check("rst_mid_cnt0", n_seen[0], 3);
    check("rst_mid_cnt3", n_seen[3], 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/in_fifo_chain.md
Name: in_fifo_chain

Overview:
- Parametrised successor to the per-node input FIFO network.
- Accepts one Avalon-ST packet stream and relays every beat down a chain of NCOUNT processing-node stages.
- Each stage is a buffer, so every node sees the whole stream in order.
- Adds over the previous generation:
  - configurable widths and depth;
  - credit-correct forwarding that accounts for the one-cycle read latency;
  - per-node bypass;
  - a programmable xoff threshold;
  - optional input framing checks.

Parameters:
- NCOUNT, 8: number of node stages, at least 1.
- DATA_W, 128: payload width.
- CHAN_W, 12: channel field width.
- DEPTH, 16: entries per stage FIFO; power of two, at least 4.
- AF_THRESH, 12: stage-0 level at which xoff asserts; 1 to DEPTH-1.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- st_data  in  DATA_W  input payload.
- st_sop  in  1  start of packet.
- st_eop  in  1  end of packet.
- st_valid  in  1  input beat valid.
- st_channel  in  CHAN_W  input channel.
- st_ready  out  1  input ready; ready latency 0.
- node_bypass  in  [NCOUNT]  node i skipped: its output is suppressed and its stage forwards freely.
- pnode_ready  in  [NCOUNT]  node i accepts its output this cycle.
- pnode_data  out  [NCOUNT] x W  word {channel, sop, eop, data}, where W = CHAN_W+2+DATA_W.
- pnode_valid  out  [NCOUNT]  one-cycle pulse per delivered word.
- xoff  out  1  registered flow-control request to the MAC.
- frame_err  out  1  sticky framing error; tied 0 without FRAME_CHK_EN.

Behaviour:
- Reset values (asynchronous): all FIFO levels 0, all pnode_valid 0, pnode_data 0, xoff 0, frame_err 0. st_ready is 0 while reset is high and 1 from the first cycle after release.
- Input write: stage 0 is written when st_valid && st_ready. st_ready = level0 < DEPTH, combinational.
- Read condition for stage i:
  - stage i is not empty, and
  - (pnode_ready[i] || node_bypass[i]), and
  - for i < NCOUNT-1: level[i+1] + out_v[i] <= DEPTH-1. This is the credit rule: a word in flight counts as occupying the downstream stage.
- Output timing: the read word is registered into out_q[i], and out_v[i] goes high the next cycle.
  - pnode_data[i] = out_q[i].
  - pnode_valid[i] = out_v[i] && !node_bypass[i].
  - Stage i+1 write enable is out_v[i], with data out_q[i].
- Latency:
  - Empty chain: input beat to pnode_valid[0] is 2 cycles (write, read, register).
  - Each further stage adds 2 cycles.
- Throughput: 1 beat per cycle when every node is ready.
- Simultaneous read and write on the same stage: level is unchanged, and a write into an empty FIFO is readable the following cycle.
- Full stage 0: st_ready = 0 and input beats are held by the source. No beat is ever dropped, except under FRAME_CHK_EN as described below.
- Stalled node i:
  - stage i fills;
  - stage i-1 stops reading once the credit rule fails;
  - upstream backpressure propagates to st_ready.
- xoff is registered:
  - set when level0 >= AF_THRESH;
  - cleared when level0 < AF_THRESH-2 (hysteresis).
- node_bypass may change at any time. A word in out_q while the stage is bypassed is still forwarded down the chain but not flagged to the node.
- Reset mid-packet discards all buffered words. Downstream nodes must treat a missing eop as aborted.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Levels are log2(DEPTH)+1 bits.

Optional Feature:
- Macro: IN_FIFO_CHAIN_FRAME_CHK_EN.
- Defined:
  - the input is tracked with an in_pkt flag;
  - a beat with sop while in_pkt, or without sop while !in_pkt, sets frame_err (sticky until reset) and is dropped (accepted but not written);
  - eop clears in_pkt;
  - a single-beat packet with sop and eop together is legal.
- Not defined: no checking, every accepted beat is written, and frame_err is constant 0.

Decomposition:
- Package in_fifo_pkg holds:
  - a function returning the word width from CHAN_W and DATA_W;
  - a word_t-style packed struct {chan, sop, eop, data}, parametrised via the package's default widths;
  - a localparam for the xoff hysteresis (2).
- Sub-module chain_stage_fifo (parameters: width, DEPTH):
  - inferred RAM plus read and write pointers and level;
  - read data registered;
  - ports: clock, reset, wrreq, data, rdreq, q, q_valid, level, empty, full.
- The top instantiates NCOUNT copies in a generate loop.

Test Plan:
- Single beat: after reset, one beat {chan=5, sop=1, eop=1, data=0xABCD} with NCOUNT=4 and all nodes ready -> pnode_valid[0..3] pulse at cycles +2, +4, +6, +8, each carrying identical data.
- Streaming: 100 back-to-back beats with all nodes ready -> st_ready never drops and each node receives 100 in-order beats at 1 per cycle.
- Stalled last node: pnode_ready[3]=0 with DEPTH=16, AF_THRESH=12 -> stage 3 holds 16 words, xoff rises once level0 reaches 12, st_ready falls at level0=16, and no stage overflows. Releasing the stall drains all words in order and xoff clears at level0 < 10.
- Bypass: node_bypass[1]=1 with pnode_ready[1]=0 -> pnode_valid[1] stays 0 and stages 2..3 still receive every beat.
- Framing (macro defined): sop, data, then sop with no eop -> frame_err=1 and the second sop beat is absent at all nodes. Without the macro, the same stimulus delivers all beats and frame_err=0.
- Reset mid-stream: assert reset with 7 words buffered -> all pnode_valid and xoff are 0 immediately, and after release a new packet is delivered with nothing left over from before the reset.
